// File: rtl/band_mixer_if.sv
// band_mixer_if: groups the sample, gain-programming and result signals of
// the band_mixer into one bundle. clk and rst stay plain ports on the mixer.
// The slave modport is the mixer; the master modport is whatever feeds it.
// The clip_count signal exists only when BAND_MIXER_CLIP_CNT_EN is defined.
interface band_mixer_if;
    logic         clk_enable;
    logic         sample_valid;
    logic [127:0] band_in;
    logic         gain_we;
    logic [2:0]   gain_addr;
    logic [15:0]  gain_data;
    logic [15:0]  mix_out;
    logic         mix_valid;
    logic         busy;
    logic         overrun;
`ifdef BAND_MIXER_CLIP_CNT_EN
    logic [15:0]  clip_count;
`endif

    modport master (
        output clk_enable, sample_valid, band_in, gain_we, gain_addr, gain_data,
        input  mix_out, mix_valid, busy, overrun
`ifdef BAND_MIXER_CLIP_CNT_EN
        , input clip_count
`endif
    );

    modport slave (
        input  clk_enable, sample_valid, band_in, gain_we, gain_addr, gain_data,
        output mix_out, mix_valid, busy, overrun
`ifdef BAND_MIXER_CLIP_CNT_EN
        , output clip_count
`endif
    );
endinterface

// File: rtl/band_mixer.sv
// band_mixer: combines the eight signed band outputs of the equalizer.
// Each band is scaled by a Q2.13 gain and summed with one serial MAC (one
// band per enabled clock), then rounded half toward +inf and saturated to a
// 16-bit signed output sample. Gains are snapshotted at sample capture so a
// mix always uses one coherent gain set.
// Optional feature: define BAND_MIXER_CLIP_CNT_EN to add a saturating count
// of clipped output samples (clip_count).
module band_mixer #(
    parameter int          GAIN_FRAC  = 13,
    parameter logic [15:0] GAIN_RESET = 16'h2000
) (
    input  logic    clk,
    input  logic    rst,
    band_mixer_if.slave bus
);

    localparam logic [1:0] ST_IDLE  = 2'd0;
    localparam logic [1:0] ST_ACCUM = 2'd1;
    localparam logic [1:0] ST_DONE  = 2'd2;

    localparam logic signed [34:0] ROUND_BIAS = 35'sd1 <<< (GAIN_FRAC - 1);
    localparam logic signed [34:0] SAT_MAX    = 35'sd32767;
    localparam logic signed [34:0] SAT_MIN    = -35'sd32768;

    logic [1:0]         state_q;
    logic [2:0]         idx_q;
    logic signed [34:0] acc_q;
    logic signed [15:0] gain_q   [8];
    logic signed [15:0] shadow_q [8];
    logic signed [15:0] sample_q [8];
    logic [15:0]        mix_out_q;
    logic               mix_valid_q;
    logic               overrun_q;

    logic signed [31:0] product;
    logic signed [34:0] product_ext;
    logic signed [34:0] rounded;
    logic signed [34:0] shifted;
    logic               clipped;
    logic [15:0]        sat_result;

`ifdef BAND_MIXER_CLIP_CNT_EN
    logic [15:0]        clip_q;
`endif

    // Gain file: host writes land on any clock edge, regardless of enable or state
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int k = 0; k < 8; k++) begin
                gain_q[k] <= GAIN_RESET;
            end
        end else if (bus.gain_we) begin
            gain_q[bus.gain_addr] <= bus.gain_data;
        end
    end

    // MAC datapath and final round/saturate of the accumulated sum
    always_comb begin
        product     = 32'(sample_q[idx_q]) * 32'(shadow_q[idx_q]);
        product_ext = 35'(product);
        rounded     = acc_q + ROUND_BIAS;
        shifted     = rounded >>> GAIN_FRAC;
        clipped     = 1'b0;
        sat_result  = shifted[15:0];
        if (shifted > SAT_MAX) begin
            clipped    = 1'b1;
            sat_result = 16'h7FFF;
        end else if (shifted < SAT_MIN) begin
            clipped    = 1'b1;
            sat_result = 16'h8000;
        end
    end

    // Control FSM: capture, eight MAC steps, then publish one output sample
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= ST_IDLE;
            idx_q       <= 3'd0;
            acc_q       <= '0;
            mix_out_q   <= '0;
            mix_valid_q <= 1'b0;
            overrun_q   <= 1'b0;
            for (int k = 0; k < 8; k++) begin
                sample_q[k] <= '0;
                shadow_q[k] <= GAIN_RESET;
            end
`ifdef BAND_MIXER_CLIP_CNT_EN
            clip_q      <= '0;
`endif
        end else begin
            mix_valid_q <= 1'b0;
            if (bus.clk_enable) begin
                if (bus.sample_valid && (state_q != ST_IDLE)) begin
                    overrun_q <= 1'b1;
                end
                case (state_q)
                    ST_IDLE: begin
                        if (bus.sample_valid) begin
                            for (int k = 0; k < 8; k++) begin
                                sample_q[k] <= bus.band_in[16*k +: 16];
                                shadow_q[k] <= gain_q[k];
                            end
                            acc_q   <= '0;
                            idx_q   <= 3'd0;
                            state_q <= ST_ACCUM;
                        end
                    end
                    ST_ACCUM: begin
                        acc_q <= acc_q + product_ext;
                        idx_q <= idx_q + 3'd1;
                        if (idx_q == 3'd7) begin
                            state_q <= ST_DONE;
                        end
                    end
                    ST_DONE: begin
                        mix_out_q   <= sat_result;
                        mix_valid_q <= 1'b1;
                        state_q     <= ST_IDLE;
`ifdef BAND_MIXER_CLIP_CNT_EN
                        if (clipped && (clip_q != 16'hFFFF)) begin
                            clip_q <= clip_q + 16'd1;
                        end
`endif
                    end
                    default: begin
                        state_q <= ST_IDLE;
                    end
                endcase
            end
        end
    end

    assign bus.mix_out   = mix_out_q;
    assign bus.mix_valid = mix_valid_q;
    assign bus.busy      = (state_q != ST_IDLE);
    assign bus.overrun   = overrun_q;
`ifdef BAND_MIXER_CLIP_CNT_EN
    assign bus.clip_count = clip_q;
`endif

endmodule

// File: tb/tb_band_mixer.sv
// tb_band_mixer: directed, self-checking bench for band_mixer.
// Inputs change 1 time unit after each rising edge; outputs are checked there.
module tb_band_mixer;

    logic clk;
    logic rst;
    int   compared;
    int   mismatched;

    band_mixer_if bus ();

    band_mixer #(
        .GAIN_FRAC  (13),
        .GAIN_RESET (16'h2000)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    // Free-running clock, period 10
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        compared++;
        assert (obs === exp)
        else begin
            mismatched++;
            $error("[TB] FAIL %s: observed %0d required %0d", tag, $signed(obs), $signed(exp));
        end
    endtask

    function automatic logic [127:0] allBands(input logic [15:0] v);
        logic [127:0] r;
        for (int k = 0; k < 8; k++) r[16*k +: 16] = v;
        return r;
    endfunction

    task automatic setGain(input logic [2:0] addr, input logic [15:0] data);
        bus.gain_we   = 1'b1;
        bus.gain_addr = addr;
        bus.gain_data = data;
        tick();
        bus.gain_we   = 1'b0;
    endtask

    // mode 0: plain; 1: second sample_valid 3 edges after capture;
    // 2: gain0 <= 1.0 written during ACCUM; 3: clk_enable toggled in ACCUM
    task automatic applyStimulus(input string tag, input logic [127:0] bands,
                                 input int exp, input int mode);
        bus.band_in      = bands;
        bus.sample_valid = 1'b1;
        bus.clk_enable   = 1'b1;
        tick();
        bus.sample_valid = 1'b0;
        checkOutput({tag, "_busy_capture"}, 32'(bus.busy), 32'd1);
        for (int i = 1; i <= 8; i++) begin
            if (mode == 3) begin
                bus.clk_enable = 1'b0;
                tick();
                bus.clk_enable = 1'b1;
            end
            if (mode == 1 && i == 3) begin
                bus.sample_valid = 1'b1;
                bus.band_in      = allBands(16'sd2000);
            end
            if (mode == 2 && i == 3) begin
                bus.gain_we   = 1'b1;
                bus.gain_addr = 3'd0;
                bus.gain_data = 16'h2000;
            end
            tick();
            bus.sample_valid = 1'b0;
            bus.gain_we      = 1'b0;
        end
        checkOutput({tag, "_valid_early"}, 32'(bus.mix_valid), 32'd0);
        checkOutput({tag, "_busy_done"}, 32'(bus.busy), 32'd1);
        tick();
        checkOutput({tag, "_valid"}, 32'(bus.mix_valid), 32'd1);
        checkOutput({tag, "_out"}, 32'(signed'(bus.mix_out)), 32'(exp));
        tick();
        checkOutput({tag, "_valid_clear"}, 32'(bus.mix_valid), 32'd0);
        checkOutput({tag, "_busy_idle"}, 32'(bus.busy), 32'd0);
    endtask

    // Linear sequence of directed steps
    initial begin
        int pulses;
        compared         = 0;
        mismatched       = 0;
        rst              = 1'b1;
        bus.clk_enable   = 1'b0;
        bus.sample_valid = 1'b0;
        bus.band_in      = '0;
        bus.gain_we      = 1'b0;
        bus.gain_addr    = '0;
        bus.gain_data    = '0;
        tick();
        tick();
        rst = 1'b0;

        checkOutput("reset_mix_out", 32'(bus.mix_out), 32'd0);
        checkOutput("reset_mix_valid", 32'(bus.mix_valid), 32'd0);
        checkOutput("reset_busy", 32'(bus.busy), 32'd0);
        checkOutput("reset_overrun", 32'(bus.overrun), 32'd0);
`ifdef BAND_MIXER_CLIP_CNT_EN
        checkOutput("reset_clip", 32'(bus.clip_count), 32'd0);
`endif

        applyStimulus("unity1000", allBands(16'sd1000), 8000, 0);
        checkOutput("overrun_clean", 32'(bus.overrun), 32'd0);

        applyStimulus("sat_pos", allBands(16'sd32767), 32767, 0);
`ifdef BAND_MIXER_CLIP_CNT_EN
        checkOutput("clip_1", 32'(bus.clip_count), 32'd1);
`endif
        applyStimulus("sat_neg", allBands(16'h8000), -32768, 0);
`ifdef BAND_MIXER_CLIP_CNT_EN
        checkOutput("clip_2", 32'(bus.clip_count), 32'd2);
`endif

        bus.clk_enable = 1'b0;
        for (int k = 0; k < 8; k++) setGain(3'(k), 16'h0000);
        setGain(3'd3, 16'h4000);
        begin
            logic [127:0] b;
            b = allBands(16'sd500);
            b[16*3 +: 16] = -16'sd1234;
            applyStimulus("band3_x2", b, -2468, 0);
        end

        setGain(3'd3, 16'h0000);
        setGain(3'd0, 16'h1000);
        applyStimulus("round_pos", 128'(16'sd3), 2, 0);
        applyStimulus("round_neg", {112'd0, 16'hFFFD}, -1, 0);
`ifdef BAND_MIXER_CLIP_CNT_EN
        checkOutput("clip_hold", 32'(bus.clip_count), 32'd2);
`endif

        applyStimulus("gain_coherent", 128'(16'sd100), 50, 2);
        applyStimulus("gain_applied", 128'(16'sd100), 100, 0);
        checkOutput("overrun_still_clear", 32'(bus.overrun), 32'd0);

        setGain(3'd0, 16'h1000);
        applyStimulus("overrun_mix", 128'(16'sd100), 50, 1);
        checkOutput("overrun_set", 32'(bus.overrun), 32'd1);

        setGain(3'd0, 16'h2000);
        applyStimulus("enable_toggle", {112'd0, 16'hFFF9}, -7, 3);

        bus.band_in      = 128'(16'sd500);
        bus.sample_valid = 1'b1;
        bus.clk_enable   = 1'b1;
        tick();
        bus.sample_valid = 1'b0;
        for (int i = 0; i < 4; i++) tick();
        rst = 1'b1;
        #2;
        checkOutput("rst_busy", 32'(bus.busy), 32'd0);
        checkOutput("rst_mix_out", 32'(bus.mix_out), 32'd0);
        checkOutput("rst_mix_valid", 32'(bus.mix_valid), 32'd0);
        checkOutput("rst_overrun", 32'(bus.overrun), 32'd0);
        rst = 1'b0;
        pulses = 0;
        for (int i = 0; i < 12; i++) begin
            tick();
            if (bus.mix_valid) pulses++;
        end
        checkOutput("rst_no_valid", 32'(pulses), 32'd0);
        checkOutput("rst_mix_out_hold", 32'(bus.mix_out), 32'd0);

        applyStimulus("after_rst_unity", allBands(16'sd1000), 8000, 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule

// File: doc/band_mixer.md
# band_mixer

Downstream combining stage of the 8-band equalizer. Takes the eight 16-bit signed band outputs of the per-band `filter` instances, scales each band by a programmable gain, and sums the results with a single serial multiply-accumulate. It then rounds and saturates the sum to one 16-bit signed equalizer output sample. The block is gated by the same `clk_enable` as the filters.

## Interface
Parameters:
- `GAIN_FRAC`, 13: fractional bits of gain; 1.0 = 2^13 = 16'h2000.
- `GAIN_RESET`, 16'h2000: reset value of every gain register (unity).

Ports:
- `clk`, in, 1: single clock.
- `rst`, in, 1: asynchronous, active-high reset.
- `clk_enable`, in, 1: state advances only on `clk` edges where this is 1.
- `sample_valid`, in, 1: all eight band inputs hold a new sample.
- `band_in`, in, 128: band k at bits [16k+15:16k], signed, k = 0..7.
- `gain_we`, in, 1: gain register write strobe.
- `gain_addr`, in, 3: band index for the write.
- `gain_data`, in, 16: signed gain, Q2.13.
- `mix_out`, out, 16: signed mixed sample; held between updates.
- `mix_valid`, out, 1: one-`clk` pulse when `mix_out` updates.
- `busy`, out, 1: 1 in the ACCUM and DONE states.
- `overrun`, out, 1: sticky; set when a sample is dropped.
- `clip_count`, out, 16: present only with `BAND_MIXER_CLIP_CNT_EN`.

## Operation
- Gain file: 8 x 16-bit registers.
  - Written when `gain_we=1` (independent of `clk_enable` and of state).
  - Writes are always accepted.
- FSM: IDLE -> ACCUM -> DONE -> IDLE.
- IDLE, when `sample_valid & clk_enable`:
  - snapshot `band_in` into 8 sample registers;
  - snapshot the 8 gains into a shadow bank, so one mix always uses a coherent gain set;
  - clear the accumulator; set idx = 0; go to ACCUM.
  - A simultaneous gain write is not in this snapshot.
- ACCUM, per enabled edge:
  - acc += sample[idx] * shadow_gain[idx];
  - the product is signed 32-bit and the accumulator is signed 35-bit, so there is no internal overflow;
  - idx++; after idx = 7 is processed, go to DONE.
- DONE, on the enabled edge:
  - r = (acc + 2^(GAIN_FRAC-1)) >>> GAIN_FRAC (arithmetic shift, round half toward +inf);
  - saturate r to [-32768, 32767];
  - `mix_out` <= r; `mix_valid` <= 1; go to IDLE.
- `sample_valid` while `busy`: the sample is ignored and `overrun` <= 1. It is cleared only by `rst`.
- `sample_valid` in the same DONE edge: also dropped (overrun). Back-to-back acceptance starts in IDLE.

## Timing
- Latency: the capture edge is enabled edge N; accumulation occupies edges N+1..N+8; `mix_out` and `mix_valid` update on edge N+9.
- Throughput: one sample per 10 enabled cycles.
- `mix_valid` is high for exactly one `clk` cycle and clears on the next `clk` edge even if `clk_enable=0`.
- With `clk_enable=0`, the FSM, idx and acc hold; latency stretches accordingly.
- Reset values:
  - `mix_out`=0, `mix_valid`=0, `busy`=0, `overrun`=0;
  - FSM in IDLE, acc=0, idx=0;
  - all gains = `GAIN_RESET`; `clip_count`=0.
- `rst` asserted mid-ACCUM aborts the mix: no `mix_valid`, outputs return to reset values immediately (asynchronous).

## Configuration
- Macro `BAND_MIXER_CLIP_CNT_EN`.
- Defined:
  - `clip_count` port exists;
  - it increments on each DONE edge where saturation occurred;
  - it saturates at 16'hFFFF; reset to 0.
- Undefined: no port, no counter logic; all other behaviour is identical.

## Test plan
- Reset, unity gains, all bands = 1000, one `sample_valid` -> `mix_valid` 9 enabled cycles after capture (edge N+9), `mix_out` = 8000, `overrun` = 0.
- All bands = 32767, unity gains -> `mix_out` = 32767, `clip_count` = 1. All bands = -32768 -> `mix_out` = -32768, `clip_count` = 2.
- Gains 0 except band 3 = 16'h4000, band 3 = -1234, others = 500 -> `mix_out` = -2468.
- Rounding: gain0 = 16'h1000, others 0. Band 0 = 3 -> `mix_out` = 2; band 0 = -3 -> `mix_out` = -1.
- Overrun/coherency:
  - second `sample_valid` 3 cycles after capture -> ignored, `overrun` = 1, result equals the first sample's mix;
  - a gain write during ACCUM does not affect the current result and applies to the next mix.
- `clk_enable` toggled 1/0 every cycle during ACCUM -> same result, `mix_valid` on the 9th enabled edge after capture. `rst` pulsed mid-ACCUM -> no `mix_valid`, `mix_out` = 0, `busy` = 0.
